// File: rtl/mesa_pkg.sv
// Shared types and constants for the MesaBus autobaud receiver.
package mesa_pkg;

    typedef enum logic [2:0] {
        UNLOCKED,
        MEASURE,
        SKIP,
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // Sync character transmitted by the host to set the bit rate.
    localparam logic [7:0] SYNC_CHAR = 8'h55;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_UA = 8'h41;
    localparam logic [7:0] ASCII_UF = 8'h46;
    localparam logic [7:0] ASCII_LA = 8'h61;
    localparam logic [7:0] ASCII_LF = 8'h66;

    // Returns {valid, value} for an ASCII hex digit.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        if (c >= ASCII_0 && c <= ASCII_9)
            return {1'b1, 4'(c - ASCII_0)};
        else if (c >= ASCII_LA && c <= ASCII_LF)
            return {1'b1, 4'(c - ASCII_LA + 8'd10)};
        else if (c >= ASCII_UA && c <= ASCII_UF)
            return {1'b1, 4'(c - ASCII_UA + 8'd10)};
        else
            return 5'd0;
    endfunction

endpackage

// File: rtl/mesa_hex_nib.sv
// Registered ASCII-hex to nibble decoder; non-hex bytes are dropped.
module mesa_hex_nib
    import mesa_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_byte_en,
    input  logic [7:0] i_byte_d,
    output logic       o_nib_en,
    output logic [3:0] o_nib_d
);

    logic [4:0] w_dec;

    assign w_dec = hex_decode(i_byte_d);

    // Strobe and capture the nibble one cycle after a valid hex byte; hold nib_d otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_nib_en <= 1'b0;
            o_nib_d  <= 4'd0;
        end else begin
            o_nib_en <= i_byte_en & w_dec[4];
            if (i_byte_en & w_dec[4])
                o_nib_d <= w_dec[3:0];
        end
    end

endmodule

// File: rtl/mesa_autobaud_rx.sv
// UART receiver that measures the bit period from a 0x55 sync start bit,
// then deserialises bytes and feeds them to the hex nibble decoder.
//
// state     | meaning
// UNLOCKED  | no bit period held, waiting for a sync start bit
// MEASURE   | counting the low time of the sync start bit
// SKIP      | letting the rest of the sync char pass (to mid stop bit)
// IDLE      | locked, waiting for a start bit
// START     | half a bit into the start bit, confirming it is still low
// DATA      | sampling 8 data bits at bit-period spacing, LSB first
// STOP      | sampling the stop bit
// WAIT_HIGH | after a framing error, waiting for the line to return high
module mesa_autobaud_rx
    import mesa_pkg::*;
#(
    parameter int CNT_BITS     = 16,
    parameter int MIN_BIT_CLKS = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset_l,
    input  logic       rxd,
    input  logic       clr_baudlock,
    output logic       baudlock,
    output logic       byte_en,
    output logic [7:0] byte_d,
    output logic       nib_en,
    output logic [3:0] nib_d,
    output logic       framing_err
);

    // Timer is wide enough for the 8.5 bit-period skip without wrapping.
    localparam int TW = CNT_BITS + 4;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_prev;
    logic                   w_rx;
    logic                   w_fall;
    logic                   w_rise;

    rx_state_t         r_state, w_state_nxt;
    logic [CNT_BITS-1:0] r_count, w_count_nxt;
    logic [CNT_BITS-1:0] r_bit_period, w_bit_period_nxt;
    logic [TW-1:0]     r_timer, w_timer_nxt;
    logic [7:0]        r_shift, w_shift_nxt;
    logic [2:0]        r_idx, w_idx_nxt;
    logic              r_brk, w_brk_nxt;
    logic              r_baudlock, w_baudlock_nxt;
    logic              r_byte_en, w_byte_en_nxt;
    logic [7:0]        r_byte_d, w_byte_d_nxt;
    logic              r_ferr, w_ferr_nxt;
    logic              w_tmr_done;
    logic [TW-1:0]     w_skip_total;

    assign w_rx         = r_sync[SYNC_STAGES-1];
    assign w_fall       = r_rx_prev & ~w_rx;
    assign w_rise       = ~r_rx_prev & w_rx;
    assign w_tmr_done   = (r_timer == TW'(1));
    assign w_skip_total = (TW'(r_count) << 3) + TW'(r_count >> 1);

    // Resynchronise the line; flops preset high so reset does not fake a start edge.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_sync    <= '1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], rxd};
            r_rx_prev <= w_rx;
        end
    end

    // State and datapath register.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state      <= UNLOCKED;
            r_count      <= '0;
            r_bit_period <= '0;
            r_timer      <= '0;
            r_shift      <= '0;
            r_idx        <= '0;
            r_brk        <= 1'b0;
            r_baudlock   <= 1'b0;
            r_byte_en    <= 1'b0;
            r_byte_d     <= '0;
            r_ferr       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_bit_period <= w_bit_period_nxt;
            r_timer      <= w_timer_nxt;
            r_shift      <= w_shift_nxt;
            r_idx        <= w_idx_nxt;
            r_brk        <= w_brk_nxt;
            r_baudlock   <= w_baudlock_nxt;
            r_byte_en    <= w_byte_en_nxt;
            r_byte_d     <= w_byte_d_nxt;
            r_ferr       <= w_ferr_nxt;
        end
    end

    // Next-state and datapath updates; clr_baudlock overrides everything.
    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_bit_period_nxt = r_bit_period;
        w_timer_nxt      = r_timer;
        w_shift_nxt      = r_shift;
        w_idx_nxt        = r_idx;
        w_brk_nxt        = r_brk;
        w_baudlock_nxt   = r_baudlock;
        w_byte_en_nxt    = 1'b0;
        w_byte_d_nxt     = r_byte_d;
        w_ferr_nxt       = 1'b0;

        if (clr_baudlock) begin
            w_state_nxt    = UNLOCKED;
            w_baudlock_nxt = 1'b0;
        end else begin
            case (r_state)
                UNLOCKED: begin
                    if (w_fall) begin
                        w_state_nxt = MEASURE;
                        w_count_nxt = CNT_BITS'(1);
                    end
                end
                MEASURE: begin
                    if (w_rise) begin
                        if (r_count >= CNT_BITS'(MIN_BIT_CLKS)) begin
                            w_bit_period_nxt = r_count;
                            w_baudlock_nxt   = 1'b1;
                            w_timer_nxt      = w_skip_total;
                            w_state_nxt      = SKIP;
                        end else begin
                            w_state_nxt = UNLOCKED;
                        end
                    end else if (r_count == '1) begin
                        w_state_nxt = UNLOCKED;
                    end else begin
                        w_count_nxt = r_count + CNT_BITS'(1);
                    end
                end
                SKIP: begin
                    if (w_tmr_done) w_state_nxt = IDLE;
                    else            w_timer_nxt = r_timer - TW'(1);
                end
                IDLE: begin
                    if (w_fall) begin
                        w_state_nxt = START;
                        w_timer_nxt = TW'(r_bit_period >> 1);
                    end
                end
                START: begin
                    if (w_tmr_done) begin
                        if (w_rx) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = DATA;
                            w_idx_nxt   = 3'd0;
                            w_timer_nxt = TW'(r_bit_period);
                        end
                    end else begin
                        w_timer_nxt = r_timer - TW'(1);
                    end
                end
                DATA: begin
                    if (w_tmr_done) begin
                        w_shift_nxt[r_idx] = w_rx;
                        w_timer_nxt        = TW'(r_bit_period);
                        w_idx_nxt          = r_idx + 3'd1;
                        if (r_idx == 3'd7) w_state_nxt = STOP;
                    end else begin
                        w_timer_nxt = r_timer - TW'(1);
                    end
                end
                STOP: begin
                    if (w_tmr_done) begin
                        if (w_rx) begin
                            w_byte_en_nxt = 1'b1;
                            w_byte_d_nxt  = r_shift;
                            w_state_nxt   = IDLE;
                        end else begin
                            // A zero byte with a missing stop bit is a break: drop lock.
                            w_ferr_nxt  = 1'b1;
                            w_brk_nxt   = (r_shift == 8'h00);
                            w_state_nxt = WAIT_HIGH;
                            if (r_shift == 8'h00) w_baudlock_nxt = 1'b0;
                        end
                    end else begin
                        w_timer_nxt = r_timer - TW'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (w_rx) w_state_nxt = r_brk ? UNLOCKED : IDLE;
                end
                default: w_state_nxt = UNLOCKED;
            endcase
        end
    end

    assign baudlock    = r_baudlock;
    assign byte_en     = r_byte_en;
    assign byte_d      = r_byte_d;
    assign framing_err = r_ferr;

    mesa_hex_nib u_hex_nib (
        .clk       (clk),
        .rst_n     (reset_l),
        .i_byte_en (r_byte_en),
        .i_byte_d  (r_byte_d),
        .o_nib_en  (nib_en),
        .o_nib_d   (nib_d)
    );

endmodule
